// File: rtl/inst_mem_loader.sv
// Loads a byte-streamed program image (count | words | xor checksum) into inst_mem, then releases the core.
// Latency: each word is written the cycle after its 4th byte; done/error the cycle after the checksum byte.
// Backpressure: in_ready is a registered state decode, high while loading and low once done or errored.
module inst_mem_loader #(
    parameter int XLEN      = 32,
    parameter int ILEN      = 32,
    parameter int MEM_WORDS = 1024,
    parameter int BASE_ADDR = 0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [7:0]      in_data,
    output logic [XLEN-1:0] mem_addr,
    output logic [ILEN-1:0] mem_wdata,
    output logic            mem_write_en,
    output logic            core_reset_n,
    output logic            done,
    output logic            error
);

    typedef enum logic [2:0] {S_HDR, S_DATA, S_CHK, S_DONE, S_ERR} state_t;

    state_t           state;
    logic [31:0]      count;
    logic [31:0]      word_idx;
    logic [1:0]       byte_cnt;
    logic [ILEN-9:0]  word_buf;
    logic [7:0]       xor_acc;

    logic             fire;
    logic [31:0]      hdr_next;
    logic [ILEN-1:0]  word_next;

    assign fire      = in_valid & in_ready;
    assign hdr_next  = {in_data, count[31:8]};
    // Only the three earlier bytes need storing; the 4th arrives with the write.
    assign word_next = {in_data, word_buf};

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_HDR;
            in_ready     <= 1'b0;
            count        <= '0;
            word_idx     <= '0;
            byte_cnt     <= '0;
            word_buf     <= '0;
            xor_acc      <= '0;
            mem_addr     <= XLEN'(BASE_ADDR);
            mem_wdata    <= '0;
            mem_write_en <= 1'b0;
            core_reset_n <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            mem_write_en <= 1'b0;
            case (state)
                S_HDR: begin
                    in_ready <= 1'b1;
                    if (fire) begin
                        count    <= hdr_next;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            if (hdr_next > 32'(MEM_WORDS)) begin
                                state    <= S_ERR;
                                error    <= 1'b1;
                                in_ready <= 1'b0;
                            end else if (hdr_next == 32'd0) begin
                                state <= S_CHK;
                            end else begin
                                state <= S_DATA;
                            end
                        end
                    end
                end
                S_DATA: begin
                    in_ready <= 1'b1;
                    if (fire) begin
                        word_buf <= word_next[ILEN-1:8];
                        xor_acc  <= xor_acc ^ in_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            mem_write_en <= 1'b1;
                            mem_wdata    <= word_next;
                            mem_addr     <= XLEN'(BASE_ADDR) + XLEN'(word_idx << 2);
                            word_idx     <= word_idx + 32'd1;
                            if (word_idx == count - 32'd1)
                                state <= S_CHK;
                        end
                    end
                end
                S_CHK: begin
                    in_ready <= 1'b1;
                    if (fire) begin
                        in_ready <= 1'b0;
                        if (in_data == xor_acc) begin
                            state        <= S_DONE;
                            done         <= 1'b1;
                            core_reset_n <= 1'b1;
                        end else begin
                            state <= S_ERR;
                            error <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    in_ready <= 1'b0;
                end
                S_ERR: begin
                    in_ready     <= 1'b0;
                    core_reset_n <= 1'b0;
                end
                default: begin
                    state    <= S_ERR;
                    error    <= 1'b1;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Bench for inst_mem_loader: table of directed streams, random streams against a queue-based model,
// and a hand-written reset-mid-word sequence.
module tb_inst_mem_loader;

    localparam int MEM_WORDS = 1024;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_write_en;
    logic        core_reset_n;
    logic        done;
    logic        error;

    inst_mem_loader #(
        .XLEN(32), .ILEN(32), .MEM_WORDS(MEM_WORDS), .BASE_ADDR(0)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_write_en (mem_write_en),
        .core_reset_n (core_reset_n),
        .done         (done),
        .error        (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] words_q[$];
    int          acc_q[$];
    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    int          obs_cyc[$];

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (mem_write_en === 1'b1) begin
            obs_addr.push_back(mem_addr);
            obs_data.push_back(mem_wdata);
            obs_cyc.push_back(cyc);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_xor();
        logic [7:0] x = 8'h00;
        foreach (words_q[k])
            for (int b = 0; b < 4; b++) x ^= words_q[k][8*b +: 8];
        return x;
    endfunction

    // Present one byte, optionally with random idle cycles, until the loader takes it.
    task automatic send(input logic [7:0] b, input int gap);
        int  waited = 0;
        bit  taken  = 0;
        while (!taken) begin
            @(negedge clock);
            if (gap > 0 && $urandom_range(99) < gap) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end else begin
                in_valid = 1'b1;
                in_data  = b;
                if (in_ready === 1'b1) begin
                    acc_q.push_back(cyc + 1);
                    taken = 1;
                end
            end
            if (!taken) begin
                waited++;
                if (waited > 200) begin
                    checks++;
                    errors++;
                    $display("FAIL send_timeout byte=%0h in_ready=%b", b, in_ready);
                    acc_q.push_back(-1);
                    in_valid = 1'b0;
                    taken = 1;
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        @(negedge clock);
        @(negedge clock);
        check("rst_in_ready", in_ready, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_we", mem_write_en, 0);
        check("rst_core_reset_n", core_reset_n, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        reset = 1'b0;
        acc_q.delete();
        obs_addr.delete();
        obs_data.delete();
        obs_cyc.delete();
    endtask

    // Stream count | words_q | chk and compare with what the image rules predict.
    task automatic run(input logic [31:0] n, input logic [7:0] chk, input int gap,
                       input bit exp_done, input bit exp_err, input int id);
        bit oversize = (n > MEM_WORDS);
        int exp_w;
        do_reset();
        for (int i = 0; i < 4; i++) send(n[8*i +: 8], gap);
        if (oversize) begin
            @(negedge clock);
            in_valid = 1'b0;
            check($sformatf("v%0d_err_after_hdr", id), error, 1);
            check($sformatf("v%0d_ready_after_hdr", id), in_ready, 0);
        end else begin
            foreach (words_q[k])
                for (int b = 0; b < 4; b++) send(words_q[k][8*b +: 8], gap);
            send(chk, gap);
            @(negedge clock);
            in_valid = 1'b0;
        end
        repeat (3) @(negedge clock);
        exp_w = oversize ? 0 : words_q.size();
        check($sformatf("v%0d_strobes", id), obs_addr.size(), exp_w);
        for (int k = 0; k < exp_w && k < obs_addr.size(); k++) begin
            check($sformatf("v%0d_addr%0d", id, k), obs_addr[k], 4 * k);
            check($sformatf("v%0d_data%0d", id, k), obs_data[k], words_q[k]);
            check($sformatf("v%0d_slot%0d", id, k), obs_cyc[k], acc_q[4 + 4*k + 3]);
        end
        check($sformatf("v%0d_done", id), done, exp_done);
        check($sformatf("v%0d_error", id), error, exp_err);
        check($sformatf("v%0d_core_reset_n", id), core_reset_n, exp_done);
        check($sformatf("v%0d_in_ready", id), in_ready, 0);
    endtask

    typedef struct {
        logic [31:0] n;
        logic [31:0] w[3];
        bit          own_chk;
        logic [7:0]  chk;
        int          gap;
        bit          exp_done;
        bit          exp_err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;

        vecs[0] = '{32'd1,     '{32'h00A00513, 32'h0, 32'h0},                   1, 8'hB6, 0,  1, 0};
        vecs[1] = '{32'd3,     '{32'h00100093, 32'h00208113, 32'hFFF00193},     0, 8'h00, 0,  1, 0};
        vecs[2] = '{32'd2,     '{32'hDEADBEEF, 32'h01234567, 32'h0},            0, 8'h00, 40, 1, 0};
        vecs[3] = '{32'h401,   '{32'h0, 32'h0, 32'h0},                          1, 8'h00, 0,  0, 1};
        vecs[4] = '{32'd1,     '{32'h00A00513, 32'h0, 32'h0},                   1, 8'h00, 0,  0, 1};
        vecs[5] = '{32'd0,     '{32'h0, 32'h0, 32'h0},                          1, 8'h00, 0,  1, 0};

        for (int v = 0; v < 6; v++) begin
            words_q.delete();
            if (vecs[v].n <= 3)
                for (int k = 0; k < int'(vecs[v].n); k++) words_q.push_back(vecs[v].w[k]);
            run(vecs[v].n, vecs[v].own_chk ? vecs[v].chk : model_xor(),
                vecs[v].gap, vecs[v].exp_done, vecs[v].exp_err, v);
        end

        for (int r = 0; r < 6; r++) begin
            int         n   = $urandom_range(5, 1);
            bit         bad = ($urandom_range(2) == 0);
            logic [7:0] c;
            words_q.delete();
            for (int k = 0; k < n; k++) words_q.push_back($urandom);
            c = model_xor();
            if (bad) c = c ^ 8'($urandom_range(255, 1));
            run(32'(n), c, $urandom_range(50), !bad, bad, 10 + r);
        end

        // Reset in the middle of word 0, then a clean one-word image.
        do_reset();
        send(8'h01, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
        send(8'hAA, 0); send(8'hBB, 0);
        @(negedge clock);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clock);
        check("midreset_in_ready", in_ready, 0);
        check("midreset_core_reset_n", core_reset_n, 0);
        check("midreset_no_write", obs_addr.size(), 0);
        reset = 1'b0;
        words_q.delete();
        words_q.push_back(32'h00A00513);
        run(32'd1, 8'hB6, 0, 1, 0, 20);

        // Reset out of DONE puts the core back into reset.
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
